fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-operand, two-stage combinational forwarding unit.
- Keeps its own shadow pipeline of destination records for the stages after ID. Generates per-operand forwarding selects for the EX stage.
- Detects load-use hazards for any load latency and requests ID stalls.
- Sits beside the ID/EX pipeline register. Datapath muxes in EX consume fwd_sel; the PC and IF/ID enable consume stall.

---
 rtl/fwd_hazard_unit.sv | 170 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use hazard detection beside the ID/EX register.
//
// Keeps a shadow pipeline of destination records for EX (stage 0) and the FWD_DEPTH stages
// after it. Stage 0 also remembers the instruction's sources so EX forwarding selects can be
// produced from registered state only.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   id_valid     ID holds a real instruction
//   id_rs        ID sources, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used  operand i is actually read
//   id_rd        ID destination register
//   id_reg_write ID instruction writes id_rd
//   id_mem_read  ID instruction is a load
//   flush        kill the ID instruction
//   stall        hold PC and IF/ID, bubble into ID/EX
//   fwd_sel      per-operand EX select, 0 = register file, k = stage k
//
// Optional build macro FWD_HAZARD_STATS_EN adds:
//   stat_clr     clear both counters
//   stall_cnt    saturating count of stall cycles
//   fwd_cnt      saturating count of cycles with any nonzero fwd_sel
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_LAT   = 1,
  localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
`ifdef FWD_HAZARD_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   fwd_cnt
`endif
);

  logic [FWD_DEPTH:0]            valid_q, valid_d, rw_q, rw_d, ld_q, ld_d;
  logic [REG_ADDR_W-1:0]         rd_q [FWD_DEPTH+1];
  logic [REG_ADDR_W-1:0]         rd_d [FWD_DEPTH+1];
  logic [NUM_SRC*REG_ADDR_W-1:0] rs0_q, rs0_d;
  logic [NUM_SRC-1:0]            used0_q, used0_d;

  logic [FWD_DEPTH:0]    elig;
  logic [REG_ADDR_W-1:0] cand_rs;
  logic                  cand_hit_ld;

  // A load only becomes a forwarding source once it is past LOAD_LAT stages after EX.
  always_comb begin
    elig = '0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      elig[k] = valid_q[k] && rw_q[k] && (rd_q[k] != '0) && (!ld_q[k] || k > int'(LOAD_LAT));
    end
  end

  // Scan old to young so the youngest match is the last assignment and wins.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
        if (valid_q[0] && used0_q[i] && elig[k] &&
            (rd_q[k] == rs0_q[i*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // Youngest writer of each source decides; a younger non-load clears an older load's hazard.
  always_comb begin
    stall       = 1'b0;
    cand_rs     = '0;
    cand_hit_ld = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      cand_rs     = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      cand_hit_ld = 1'b0;
      for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
        if (valid_q[k] && rw_q[k] && (rd_q[k] == cand_rs)) begin
          cand_hit_ld = ld_q[k] && (k + 1 <= int'(LOAD_LAT));
        end
      end
      if (id_valid && !flush && id_src_used[i] && (cand_rs != '0) && cand_hit_ld) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = '0;
    rw_d    = '0;
    ld_d    = '0;
    for (int k = 0; k <= int'(FWD_DEPTH); k++) rd_d[k] = '0;
    rs0_d   = '0;
    used0_d = '0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      valid_d[k] = valid_q[k-1];
      rw_d[k]    = rw_q[k-1];
      ld_d[k]    = ld_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    if (id_valid && !flush && !stall) begin
      valid_d[0] = 1'b1;
      rw_d[0]    = id_reg_write;
      ld_d[0]    = id_mem_read;
      rd_d[0]    = id_rd;
      rs0_d      = id_rs;
      used0_d    = id_src_used;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rw_q    <= '0;
      ld_q    <= '0;
      for (int k = 0; k <= int'(FWD_DEPTH); k++) rd_q[k] <= '0;
      rs0_q   <= '0;
      used0_q <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      for (int k = 0; k <= int'(FWD_DEPTH); k++) rd_q[k] <= rd_d[k];
      rs0_q   <= rs0_d;
      used0_q <= used0_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if ((|fwd_sel) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instance A uses defaults (FWD_DEPTH=2, LOAD_LAT=1), instance B uses
// FWD_DEPTH=3, LOAD_LAT=2. Directed scenarios check hand-derived values; a random phase checks
// both instances against a record-list model of the forwarding and stall rules.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       flush = 1'b0;
  logic       stat_clr = 1'b0;
  logic       stall_a, stall_b;
  logic [3:0] fwd_a, fwd_b;
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall_a), .fwd_sel(fwd_a)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_clr(stat_clr), .stall_cnt(scnt_a), .fwd_cnt(fcnt_a)
`endif
  );

  fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall_b), .fwd_sel(fwd_b)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_clr(stat_clr), .stall_cnt(scnt_b), .fwd_cnt(fcnt_b)
`endif
  );

`ifndef FWD_HAZARD_STATS_EN
  assign scnt_a = '0;
  assign fcnt_a = '0;
  assign scnt_b = '0;
  assign fcnt_b = '0;
`endif

  // Model: p[k] is the instruction currently k stages past ID (0 = in EX).
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [9:0] rs;
    logic [1:0] used;
  } rec_t;
  typedef rec_t rec_arr_t [8];

  rec_arr_t    ma, mb;
  int unsigned m_scnt = 0;
  int unsigned m_fcnt = 0;

  function automatic logic mstall(input rec_arr_t p, input int depth, input int lat);
    logic [4:0] rs;
    for (int i = 0; i < 2; i++) begin
      rs = id_rs[i*5 +: 5];
      if (id_valid && !flush && id_src_used[i] && rs != 5'd0) begin
        for (int k = 0; k < depth; k++) begin
          if (p[k].v && p[k].rw && p[k].rd == rs) begin
            if (p[k].ld && k + 1 <= lat) return 1'b1;
            break;
          end
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] mfwd(input rec_arr_t p, input int depth, input int lat);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      if (p[0].v && p[0].used[i]) begin
        for (int k = 1; k <= depth; k++) begin
          if (p[k].v && p[k].rw && p[k].rd != 5'd0 && p[k].rd == p[0].rs[i*5 +: 5] &&
              (!p[k].ld || k > lat)) begin
            r[i*2 +: 2] = 2'(k);
            break;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic madv(input rec_arr_t p, input int depth, input int lat, output rec_arr_t n);
    logic st;
    st = mstall(p, depth, lat);
    for (int k = 0; k < 8; k++) n[k] = '0;
    if (rst_n) begin
      for (int k = 1; k <= depth; k++) n[k] = p[k-1];
      if (id_valid && !flush && !st)
        n[0] = '{v: 1'b1, rd: id_rd, rw: id_reg_write, ld: id_mem_read, rs: id_rs,
                 used: id_src_used};
    end
  endtask

  task automatic tick();
    logic       sa;
    logic [3:0] fa;
    sa = mstall(ma, 2, 1);
    fa = mfwd(ma, 2, 1);
    @(posedge clk);
    if (!rst_n || stat_clr) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (sa && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (fa != 4'd0 && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end
    madv(ma, 2, 1, ma);
    madv(mb, 3, 2, mb);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used, input logic rw,
                       input logic ld);
    id_valid     = v;
    id_rd        = rd;
    id_rs        = {rs1, rs0};
    id_src_used  = used;
    id_reg_write = rw;
    id_mem_read  = ld;
    flush        = 1'b0;
    #1;
  endtask

  task automatic bubble();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    bubble();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bubble();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL reset_stall_a got=%b exp=0", stall_a); end
    checks++; if (fwd_a !== 4'd0) begin failures++; $display("FAIL reset_fwd_a got=%h exp=0", fwd_a); end
    checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL reset_stall_b got=%b exp=0", stall_b); end
    checks++; if (fwd_b !== 4'd0) begin failures++; $display("FAIL reset_fwd_b got=%h exp=0", fwd_b); end
`ifdef FWD_HAZARD_STATS_EN
    checks++; if (scnt_a !== 32'd0 || fcnt_a !== 32'd0) begin failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", scnt_a, fcnt_a); end
`endif
  endtask

  task automatic test_alu_fwd();
    drain();
    issue(1'b1, 5'd3, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);   // add r3,r1,r2
    tick();
    issue(1'b1, 5'd4, 5'd3, 5'd5, 2'b11, 1'b1, 1'b0);   // sub r4,r3,r5
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'b0001) begin failures++; $display("FAIL alu_fwd got=%b exp=0001", fwd_a); end
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL alu_stall2 got=%b exp=0", stall_a); end
  endtask

  task automatic load_use_seq();
    issue(1'b1, 5'd3, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);   // lw r3,0(r1)
    tick();
    issue(1'b1, 5'd6, 5'd3, 5'd3, 2'b11, 1'b1, 1'b0);   // add r6,r3,r3
    checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%b exp=1", stall_a); end
    tick();
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'b1010) begin failures++; $display("FAIL lu_fwd got=%b exp=1010", fwd_a); end
  endtask

  task automatic test_load_use();
    drain();
    load_use_seq();
  endtask

  task automatic test_youngest_wins();
    drain();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);   // add r7
    tick();
    issue(1'b1, 5'd7, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);   // lw r7
    tick();
    issue(1'b1, 5'd8, 5'd7, 5'd0, 2'b01, 1'b1, 1'b0);   // consumer of r7
    checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL yw_stall1 got=%b exp=1", stall_a); end
    tick();
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL yw_stall2 got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'b0010) begin failures++; $display("FAIL yw_fwd got=%b exp=0010", fwd_a); end
    drain();
    issue(1'b1, 5'd7, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);   // lw r7
    tick();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);   // add r7
    tick();
    issue(1'b1, 5'd8, 5'd7, 5'd0, 2'b01, 1'b1, 1'b0);
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'b0001) begin failures++; $display("FAIL sw_fwd got=%b exp=0001", fwd_a); end
  endtask

  task automatic test_r0_nowrite();
    drain();
    issue(1'b1, 5'd0, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);   // writes r0
    tick();
    issue(1'b1, 5'd4, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0);
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'd0) begin failures++; $display("FAIL r0_fwd got=%b exp=0000", fwd_a); end
    drain();
    issue(1'b1, 5'd5, 5'd1, 5'd2, 2'b11, 1'b0, 1'b1);   // rd=r5 but no write
    tick();
    issue(1'b1, 5'd4, 5'd5, 5'd5, 2'b11, 1'b1, 1'b0);
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL nw_stall got=%b exp=0", stall_a); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'd0) begin failures++; $display("FAIL nw_fwd got=%b exp=0000", fwd_a); end
  endtask

  task automatic test_deep_load_flush();
    drain();
    issue(1'b1, 5'd9, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);   // lw r9
    tick();
    issue(1'b1, 5'd10, 5'd9, 5'd0, 2'b01, 1'b1, 1'b0);
    checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL deep_stall1 got=%b exp=1", stall_b); end
    tick();
    checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL deep_stall2 got=%b exp=1", stall_b); end
    tick();
    checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL deep_stall3 got=%b exp=0", stall_b); end
    tick();
    bubble();
    checks++; if (fwd_b !== 4'b0011) begin failures++; $display("FAIL deep_fwd got=%b exp=0011", fwd_b); end
    drain();
    issue(1'b1, 5'd9, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd10, 5'd9, 5'd0, 2'b01, 1'b1, 1'b0);
    checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL fl_pre got=%b exp=1", stall_b); end
    flush = 1'b1;
    #1;
    checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall_b); end
    tick();
    bubble();
    for (int c = 0; c < 3; c++) begin
      checks++; if (fwd_b !== 4'd0) begin failures++; $display("FAIL fl_fwd%0d got=%b exp=0000", c, fwd_b); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    issue(1'b1, 5'd3, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd6, 5'd3, 5'd3, 2'b11, 1'b1, 1'b0);
    checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL rms_pre got=%b exp=1", stall_a); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL rms_stall_a got=%b exp=0", stall_a); end
    checks++; if (fwd_a !== 4'd0) begin failures++; $display("FAIL rms_fwd_a got=%b exp=0", fwd_a); end
    checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL rms_stall_b got=%b exp=0", stall_b); end
    tick();
    bubble();
    checks++; if (fwd_a !== 4'd0) begin failures++; $display("FAIL rms_fwd2 got=%b exp=0", fwd_a); end
  endtask

  task automatic test_stats();
`ifdef FWD_HAZARD_STATS_EN
    drain();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    load_use_seq();
    tick();
    checks++; if (scnt_a !== 32'd1) begin failures++; $display("FAIL st_stall_cnt got=%0d exp=1", scnt_a); end
    checks++; if (fcnt_a !== 32'd1) begin failures++; $display("FAIL st_fwd_cnt got=%0d exp=1", fcnt_a); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++; if (scnt_a !== 32'd0 || fcnt_a !== 32'd0) begin failures++;
      $display("FAIL st_clr got=%0d/%0d exp=0/0", scnt_a, fcnt_a); end
`endif
  endtask

  task automatic test_random();
    logic [3:0] ef;
    logic       es;
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      stat_clr = ($urandom_range(0, 99) == 0);
      issue(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 2) == 0));
      flush = ($urandom_range(0, 9) == 0);
      #1;
      es = mstall(ma, 2, 1);
      ef = mfwd(ma, 2, 1);
      checks++; if (stall_a !== es) begin failures++; $display("FAIL rnd_stall_a n=%0d got=%b exp=%b", n, stall_a, es); end
      checks++; if (fwd_a !== ef) begin failures++; $display("FAIL rnd_fwd_a n=%0d got=%b exp=%b", n, fwd_a, ef); end
      es = mstall(mb, 3, 2);
      ef = mfwd(mb, 3, 2);
      checks++; if (stall_b !== es) begin failures++; $display("FAIL rnd_stall_b n=%0d got=%b exp=%b", n, stall_b, es); end
      checks++; if (fwd_b !== ef) begin failures++; $display("FAIL rnd_fwd_b n=%0d got=%b exp=%b", n, fwd_b, ef); end
`ifdef FWD_HAZARD_STATS_EN
      checks++; if (scnt_a !== m_scnt || fcnt_a !== m_fcnt) begin failures++;
        $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, scnt_a, fcnt_a, m_scnt, m_fcnt); end
`endif
      tick();
    end
    rst_n    = 1'b1;
    stat_clr = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest_wins();
    test_r0_nowrite();
    test_deep_load_flush();
    test_reset_mid_stall();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
